// File: rtl/seq_mirror_if.sv
// Character stream in, frame verdict and statistics out, between the UART RX
// decoder (master) and the sequence checker (slave).
interface seq_mirror_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]       ascii_char;
    logic             char_valid;
    logic             sequence_valid;
    logic             output_strobe;
    logic [2:0]       result_code;
    logic [LEN_W-1:0] left_len;
    logic [CNT_W-1:0] frames_total;
    logic [CNT_W-1:0] frames_ok;

    modport master (
        output ascii_char, char_valid,
        input  sequence_valid, output_strobe, result_code, left_len,
               frames_total, frames_ok
    );

    modport slave (
        input  ascii_char, char_valid,
        output sequence_valid, output_strobe, result_code, left_len,
               frames_total, frames_ok
    );
endinterface

// File: rtl/seq_mirror_checker.sv
// Streaming checker for <DELIM> left <SEP> right <DELIM> frames: buffers the left
// half, compares the right half on the fly (mirrored or repeated), one verdict per frame.
module seq_mirror_checker #(
    parameter int         MAX_LEN    = 16,
    parameter logic [7:0] SEP_CHAR   = 8'h2B,
    parameter logic [7:0] DELIM_CHAR = 8'h00,
    parameter int         MODE       = 0,
    parameter int         CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    seq_mirror_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    localparam logic [2:0] C_OK         = 3'd0;
    localparam logic [2:0] C_MISMATCH   = 3'd1;
    localparam logic [2:0] C_LENGTH     = 3'd2;
    localparam logic [2:0] C_NO_SEP     = 3'd3;
    localparam logic [2:0] C_OVERFLOW   = 3'd4;
    localparam logic [2:0] C_EMPTY_LEFT = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT, S_DISCARD} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] ridx_q, ridx_d;
    logic             mis_q, mis_d;
    logic             lenf_q, lenf_d;
    logic [2:0]       dcode_q, dcode_d;
    logic [7:0]       buf_q [MAX_LEN];

    logic             sv_q, strobe_q;
    logic [2:0]       code_q;
    logic [LEN_W-1:0] llen_q;
    logic [CNT_W-1:0] tot_q, ok_q;

    logic             is_delim, is_sep, wr_en, issue;
    logic [2:0]       vcode;
    logic [LEN_W-1:0] rd_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign is_delim = (bus.ascii_char == DELIM_CHAR);
    assign is_sep   = (bus.ascii_char == SEP_CHAR);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ridx_d  = ridx_q;
        mis_d   = mis_q;
        lenf_d  = lenf_q;
        dcode_d = dcode_q;
        wr_en   = 1'b0;
        issue   = 1'b0;
        vcode   = C_OK;
        // Mirror mode walks the left half backwards from its last character
        rd_idx  = (MODE == 0) ? LEN_W'(count_q - 1'b1 - ridx_q) : ridx_q;
        if (bus.char_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_delim) begin
                        state_d = S_LEFT;
                        count_d = '0;
                    end
                end
                S_LEFT: begin
                    if (is_delim) begin
                        if (count_q != '0) begin
                            issue = 1'b1;
                            vcode = C_NO_SEP;
                        end
                        count_d = '0;
                    end else if (is_sep) begin
                        if (count_q == '0) begin
                            state_d = S_DISCARD;
                            dcode_d = C_EMPTY_LEFT;
                        end else begin
                            state_d = S_RIGHT;
                            ridx_d  = '0;
                            mis_d   = 1'b0;
                            lenf_d  = 1'b0;
                        end
                    end else if (count_q == LEN_W'(MAX_LEN)) begin
                        state_d = S_DISCARD;
                        dcode_d = C_OVERFLOW;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
                S_RIGHT: begin
                    if (is_delim) begin
                        issue = 1'b1;
                        if (mis_q)                              vcode = C_MISMATCH;
                        else if (lenf_q || (ridx_q != count_q)) vcode = C_LENGTH;
                        else                                    vcode = C_OK;
                        state_d = S_LEFT;
                        count_d = '0;
                    end else if (ridx_q < count_q) begin
                        if (bus.ascii_char != buf_q[rd_idx[IDX_W-1:0]]) mis_d = 1'b1;
                        ridx_d = ridx_q + 1'b1;
                    end else begin
                        lenf_d = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (is_delim) begin
                        issue   = 1'b1;
                        vcode   = dcode_q;
                        state_d = S_LEFT;
                        count_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            ridx_q   <= '0;
            mis_q    <= 1'b0;
            lenf_q   <= 1'b0;
            dcode_q  <= C_OK;
            sv_q     <= 1'b0;
            strobe_q <= 1'b0;
            code_q   <= C_OK;
            llen_q   <= '0;
            tot_q    <= '0;
            ok_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ridx_q   <= ridx_d;
            mis_q    <= mis_d;
            lenf_q   <= lenf_d;
            dcode_q  <= dcode_d;
            strobe_q <= issue;
            if (issue) begin
                sv_q   <= (vcode == C_OK);
                code_q <= vcode;
                llen_q <= count_q;
                tot_q  <= sat_inc(tot_q);
                if (vcode == C_OK) ok_q <= sat_inc(ok_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[count_q[IDX_W-1:0]] <= bus.ascii_char;
    end

    assign bus.sequence_valid = sv_q;
    assign bus.output_strobe  = strobe_q;
    assign bus.result_code    = code_q;
    assign bus.left_len       = llen_q;
    assign bus.frames_total   = tot_q;
    assign bus.frames_ok      = ok_q;
endmodule

// File: tb/tb_seq_mirror_checker.sv
// Bench for seq_mirror_checker: three builds (mirror/16, mirror/4 with 3-bit counters,
// repeat/16) share one character stream and are checked against a frame-level model.
module tb_seq_mirror_checker;
    localparam logic [7:0] DELIM = 8'h00;
    localparam logic [7:0] SEP   = 8'h2B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ch  = 8'h00;
    logic       vld = 1'b0;

    always #5 clk = ~clk;

    seq_mirror_if #(.MAX_LEN(16), .CNT_W(16)) if_a ();
    seq_mirror_if #(.MAX_LEN(4),  .CNT_W(3))  if_b ();
    seq_mirror_if #(.MAX_LEN(16), .CNT_W(16)) if_c ();

    assign if_a.ascii_char = ch;  assign if_a.char_valid = vld;
    assign if_b.ascii_char = ch;  assign if_b.char_valid = vld;
    assign if_c.ascii_char = ch;  assign if_c.char_valid = vld;

    seq_mirror_checker #(.MAX_LEN(16), .MODE(0), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_mirror_checker #(.MAX_LEN(4),  .MODE(0), .CNT_W(3))  u_b (.clk(clk), .rst(rst), .bus(if_b));
    seq_mirror_checker #(.MAX_LEN(16), .MODE(1), .CNT_W(16)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    int a_sv[3], a_st[3], a_code[3], a_len[3], a_tot[3], a_ok[3];
    always_comb begin
        a_sv[0] = int'(if_a.sequence_valid); a_st[0] = int'(if_a.output_strobe);
        a_code[0] = int'(if_a.result_code);  a_len[0] = int'(if_a.left_len);
        a_tot[0] = int'(if_a.frames_total);  a_ok[0] = int'(if_a.frames_ok);
        a_sv[1] = int'(if_b.sequence_valid); a_st[1] = int'(if_b.output_strobe);
        a_code[1] = int'(if_b.result_code);  a_len[1] = int'(if_b.left_len);
        a_tot[1] = int'(if_b.frames_total);  a_ok[1] = int'(if_b.frames_ok);
        a_sv[2] = int'(if_c.sequence_valid); a_st[2] = int'(if_c.output_strobe);
        a_code[2] = int'(if_c.result_code);  a_len[2] = int'(if_c.left_len);
        a_tot[2] = int'(if_c.frames_total);  a_ok[2] = int'(if_c.frames_ok);
    end

    // Model parameters per build
    int p_max[3]  = '{16, 4, 16};
    int p_mode[3] = '{0, 0, 1};
    int p_cmax[3] = '{65535, 7, 65535};

    // Frame-level reference: collect the whole frame body, judge it at the closing delimiter
    int         in_frame[3];
    logic [7:0] fb[3][256];
    int         fl[3];
    int e_sv[3], e_st[3], e_code[3], e_len[3], e_tot[3], e_ok[3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", name, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            in_frame[i] = 0; fl[i] = 0;
            e_sv[i] = 0; e_st[i] = 0; e_code[i] = 0; e_len[i] = 0; e_tot[i] = 0; e_ok[i] = 0;
        end
    endtask

    task automatic judge(input int i);
        int s, code, len, rl, mis, m;
        logic [7:0] expc;
        m = p_max[i];
        s = -1;
        for (int k = fl[i] - 1; k >= 0; k--) if (fb[i][k] == SEP) s = k;
        if (s < 0) begin
            if (fl[i] > m) begin code = 4; len = m; end
            else begin code = 3; len = fl[i]; end
        end else if (s == 0) begin
            code = 5; len = 0;
        end else if (s > m) begin
            code = 4; len = m;
        end else begin
            rl = fl[i] - s - 1;
            mis = 0;
            for (int k = 0; k < rl && k < s; k++) begin
                expc = (p_mode[i] == 1) ? fb[i][k] : fb[i][s-1-k];
                if (fb[i][s+1+k] != expc) mis = 1;
            end
            code = mis ? 1 : ((rl != s) ? 2 : 0);
            len = s;
        end
        e_st[i] = 1;
        e_sv[i] = (code == 0) ? 1 : 0;
        e_code[i] = code;
        e_len[i] = len;
        if (e_tot[i] < p_cmax[i]) e_tot[i]++;
        if (code == 0 && e_ok[i] < p_cmax[i]) e_ok[i]++;
    endtask

    task automatic model_char(input int i, input logic [7:0] c);
        if (c == DELIM) begin
            if (in_frame[i] != 0 && fl[i] > 0) judge(i);
            in_frame[i] = 1;
            fl[i] = 0;
        end else if (in_frame[i] != 0) begin
            if (fl[i] < 256) fb[i][fl[i]] = c;
            fl[i]++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("strobe", i, a_st[i], e_st[i]);
            chk("seq_valid", i, a_sv[i], e_sv[i]);
            chk("code", i, a_code[i], e_code[i]);
            chk("left_len", i, a_len[i], e_len[i]);
            chk("frames_total", i, a_tot[i], e_tot[i]);
            chk("frames_ok", i, a_ok[i], e_ok[i]);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c);
        ch = c;
        vld = v;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            e_st[i] = 0;
            if (v) model_char(i, c);
        end
        #1;
        check_all();
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        vld = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_reset();
            #1;
            check_all();
        end
        rst = 1'b0;
    endtask

    task automatic send_str(input logic [8*12-1:0] body, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            step(1'b1, body[8*(n-1-k) +: 8]);
            if (gaps && $urandom_range(3) == 0) step(1'b0, 8'h55);
        end
    endtask

    typedef struct {
        logic [8*12-1:0] body;
        int n;
        int ca, cb, cc;
        int la, lb, lc;
    } vec_t;

    vec_t vt[10];
    int strobe_cyc[$];
    int nstrobe;

    initial begin
        vt[0] = '{"012+210",     7,  0, 0, 1,  3, 3, 3};
        vt[1] = '{"012+10",      6,  1, 1, 1,  3, 3, 3};
        vt[2] = '{"012+21",      6,  2, 2, 1,  3, 3, 3};
        vt[3] = '{"012+2100",    8,  2, 2, 1,  3, 3, 3};
        vt[4] = '{"0120",        4,  3, 3, 3,  4, 4, 4};
        vt[5] = '{"+5",          2,  5, 5, 5,  0, 0, 0};
        vt[6] = '{"01234+43210", 11, 0, 4, 1,  5, 4, 5};
        vt[7] = '{"ab+ba",       5,  0, 0, 1,  2, 2, 2};
        vt[8] = '{"012+012",     7,  1, 1, 0,  3, 3, 3};
        vt[9] = '{"a+a",         3,  0, 0, 0,  1, 1, 1};

        model_reset();
        do_reset(2);
        step(1'b1, DELIM);

        for (int t = 0; t < 10; t++) begin
            send_str(vt[t].body, vt[t].n, 1'b1);
            step(1'b1, DELIM);
            chk("tbl_strobe", t, a_st[0] + a_st[1] + a_st[2], 3);
            chk("tbl_code_a", t, a_code[0], vt[t].ca);
            chk("tbl_code_b", t, a_code[1], vt[t].cb);
            chk("tbl_code_c", t, a_code[2], vt[t].cc);
            chk("tbl_len_a", t, a_len[0], vt[t].la);
            chk("tbl_len_b", t, a_len[1], vt[t].lb);
            chk("tbl_len_c", t, a_len[2], vt[t].lc);
            chk("tbl_sv_a", t, a_sv[0], (vt[t].ca == 0) ? 1 : 0);
            step(1'b0, 8'h55);
            chk("tbl_hold_code_a", t, a_code[0], vt[t].ca);
        end
        chk("tbl_total_a", 0, a_tot[0], 10);
        chk("tbl_ok_a", 0, a_ok[0], 4);
        chk("tbl_total_b_sat", 1, a_tot[1], 7);
        chk("tbl_ok_b", 1, a_ok[1], 3);

        // Reset in the middle of the right half
        send_str("012+2", 5, 1'b0);
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_sv", i, a_sv[i], 0);
            chk("rst_code", i, a_code[i], 0);
            chk("rst_total", i, a_tot[i], 0);
        end
        send_str("9+9", 3, 1'b0);
        step(1'b1, DELIM);
        chk("rst_no_strobe", 0, a_st[0], 0);
        send_str("7+7", 3, 1'b0);
        step(1'b1, DELIM);
        chk("rst_recover_strobe", 0, a_st[0], 1);
        chk("rst_recover_code", 0, a_code[0], 0);
        chk("rst_recover_total", 0, a_tot[0], 1);

        // Back-to-back frames sharing delimiters, then repeated delimiters
        strobe_cyc.delete();
        send_str("1+1", 3, 1'b0);
        if (a_st[0] != 0) strobe_cyc.push_back(cyc);
        send_str({8'h00, "2+2", 8'h00}, 5, 1'b0);
        if (a_st[0] != 0) strobe_cyc.push_back(cyc);
        // first frame's strobe is observed right after its closing delimiter
        chk("b2b_last_code", 0, a_code[0], 0);
        chk("b2b_total", 0, a_tot[0], 3);
        nstrobe = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, DELIM);
            nstrobe += a_st[0];
        end
        chk("rep_delim_strobes", 0, nstrobe, 0);

        // Measure spacing of two back-to-back verdicts explicitly
        strobe_cyc.delete();
        begin
            logic [8*12-1:0] seq;
            seq = {"1+1", 8'h00, "2+2", 8'h00};
            for (int k = 0; k < 8; k++) begin
                step(1'b1, seq[8*(7-k) +: 8]);
                if (a_st[0] != 0) strobe_cyc.push_back(cyc);
            end
        end
        chk("b2b_strobe_count", 0, strobe_cyc.size(), 2);
        if (strobe_cyc.size() == 2) chk("b2b_spacing", 0, strobe_cyc[1] - strobe_cyc[0], 4);
        chk("b2b_ok_a", 0, a_sv[0], 1);

        // Randomized stream against the reference model
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(99);
            if (r < 15)      c = DELIM;
            else if (r < 30) c = SEP;
            else             c = 8'h30 + 8'($urandom_range(3));
            step(($urandom_range(3) != 0) ? 1'b1 : 1'b0, c);
            if ($urandom_range(999) == 0) do_reset(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_mirror_checker.md
Name: seq_mirror_checker

Overview:
Streaming checker for ASCII frames of the form `<DELIM> left <SEP> right <DELIM>`. The block stores the left half in an internal buffer and compares the right half against it on the fly. Comparison is either mirrored (right half equals left half reversed) or repeated (right half equals left half). It emits one verdict per frame with an error code and keeps saturating frame statistics. It is the parametrised successor of the fixed "012+210" sequence verifier and sits between the UART RX character decoder and the UART TX result reporter.

Parameters:
- MAX_LEN, 16: maximum left-half length in characters; sets buffer depth (≥2).
- SEP_CHAR, 8'h2B: separator character ('+').
- DELIM_CHAR, 8'h00: frame delimiter character.
- MODE, 0: comparison mode. 0 = mirror (right compared against left reversed); 1 = repeat (right compared against left in order).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ascii_char  in  8  input character; sampled only when char_valid=1.
- char_valid  in  1  one-cycle qualifier; one character is accepted per cycle; there is no backpressure.
- sequence_valid  out  1  verdict of the last completed frame (1 = match); held until the next verdict.
- output_strobe  out  1  one-cycle pulse when a new verdict is loaded.
- result_code  out  3  0 OK, 1 MISMATCH, 2 LENGTH, 3 NO_SEP, 4 OVERFLOW, 5 EMPTY_LEFT; held with sequence_valid.
- left_len  out  $clog2(MAX_LEN+1)  left-half length of the last judged frame.
- frames_total  out  CNT_W  number of verdicts issued; saturates at all-ones.
- frames_ok  out  CNT_W  number of OK verdicts; saturates at all-ones.

Behaviour:
- Reset (synchronous, any state, including mid-frame):
  - State → IDLE; count, ridx and flags cleared.
  - All outputs 0: sequence_valid=0, output_strobe=0, result_code=0, left_len=0, counters=0.
  - Buffer contents are don't-care.
- States: IDLE, LEFT, RIGHT, DISCARD. Only cycles with char_valid=1 advance the FSM.
- IDLE:
  - All characters are ignored until DELIM_CHAR arrives, then → LEFT with count=0.
- LEFT:
  - DELIM with count=0: stay in LEFT. Empty frames and back-to-back delimiters produce no verdict.
  - DELIM with count>0: verdict NO_SEP; stay in LEFT with count=0.
  - SEP with count=0: → DISCARD, code EMPTY_LEFT latched.
  - SEP with count>0: → RIGHT with ridx=0, flags cleared.
  - Any other char with count<MAX_LEN: buf[count]←char, count++.
  - Any other char with count==MAX_LEN: → DISCARD, code OVERFLOW latched.
- RIGHT:
  - Every non-DELIM char, including a second SEP, is treated as data.
  - If ridx<count: compare against buf[count-1-ridx] (MODE 0) or buf[ridx] (MODE 1). On the first difference set mis_flag (sticky). Then ridx++.
  - If ridx==count (right half longer than left): set len_flag, ridx holds.
  - DELIM ends the frame. Code is MISMATCH if mis_flag; else LENGTH if len_flag or ridx≠count; else OK. Issue verdict → LEFT with count=0.
- DISCARD:
  - Characters are ignored until DELIM, then the latched code is issued as the verdict → LEFT with count=0.
- Verdict timing:
  - On the clock edge that samples the terminating DELIM, register the outputs. output_strobe=1, sequence_valid=(code==OK) and result_code, left_len, frames_total and frames_ok all become visible the cycle after the DELIM beat.
  - output_strobe returns to 0 on the next cycle regardless of inputs.
- Stream continuity: the terminating DELIM also opens the next frame; a following frame may start on the very next cycle.
- Counters: increment on each strobe; they hold at 2^CNT_W-1.
- char_valid=0 cycles are pure idle; gaps of any length between characters are allowed.

Test Plan:
- Reset, then MODE=0: frame 0,'0','1','2','+','2','1','0',0 → one strobe; sequence_valid=1, result_code=0, left_len=3, frames_total=1, frames_ok=1.
- MODE=0: frame 0,"012+10",0 → '1' is compared against '2' → sequence_valid=0, result_code=1, frames_total=2, frames_ok unchanged. Prior to this frame, sequence_valid stays 1 from the previous verdict.
- MODE=0: "012+21" → code 2 (LENGTH). "012+2100" with the trailing '0' sent as data 8'h30 → code 2. "0120" with no '+' → code 3. "+5" → code 5.
- MAX_LEN=4: frame "01234+43210" → code 4 at the closing DELIM; the next frame "ab+ba" → OK, confirming recovery. MODE=1 build: "012+012" → OK; "012+210" → code 1.
- Assert rst in the middle of the RIGHT phase → all outputs 0, no strobe. Chars before the next DELIM are ignored; a following valid frame yields OK with frames_total=1.
- Back-to-back frames with no gap cycles and single shared delimiters (0,"1+1",0,"2+2",0) → two strobes exactly 4 cycles apart, both OK. Repeated delimiters (0,0,0) → no strobe.
